// File: rtl/pico_mem_dma_pkg.sv
// Shared definitions for the picorv32-native-bus copy engine: FSM states,
// write-strobe patterns and job status codes.
package pico_mem_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } dma_state_t;

    localparam logic [3:0] WSTRB_RD   = 4'h0;
    localparam logic [3:0] WSTRB_WORD = 4'hF;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pico_mem_dma_bus_timeout_ctr.sv
// Bus watchdog: counts consecutive stalled request cycles. The expired flag
// fires on the TIMEOUT-th consecutive stall cycle. TIMEOUT=0 disables it.
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || ack || !stall) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && stall && !ack && (cnt == LAST);

endmodule

// File: rtl/pico_mem_dma.sv
// Word-copy DMA initiator on the picorv32 native memory interface: each word
// is one read beat followed immediately by one write beat.
module pico_mem_dma
    import pico_mem_dma_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    dma_state_t       state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] remaining;
    logic             expired;

    assign mem_instr = 1'b0;

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .stall   (mem_valid && !mem_ready),
        .ack     (mem_valid && mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= WSTRB_RD;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        err       <= ERR_OK;
                        if (!is_word_aligned(src_addr) || !is_word_aligned(dst_addr)) begin
                            err   <= ERR_ALIGN;
                            state <= ST_FIN;
                        end else if (len == '0) begin
                            state <= ST_FIN;
                        end else begin
                            state     <= ST_RD;
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr;
                            mem_wstrb <= WSTRB_RD;
                        end
                    end
                end
                ST_RD: begin
                    // mem_valid is always high in RD/WR, so mem_ready alone marks the handshake
                    if (mem_ready) begin
                        mem_wdata <= mem_rdata;
                        mem_addr  <= dst;
                        mem_wstrb <= WSTRB_WORD;
                        state     <= ST_WR;
                    end else if (expired) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= WSTRB_RD;
                        err       <= ERR_TIMEOUT;
                        state     <= ST_FIN;
                    end
                end
                ST_WR: begin
                    if (mem_ready) begin
                        remaining <= remaining - 1'b1;
                        src       <= src + 32'd4;
                        dst       <= dst + 32'd4;
                        mem_wstrb <= WSTRB_RD;
                        if (remaining == LEN_W'(1)) begin
                            mem_valid <= 1'b0;
                            state     <= ST_FIN;
                        end else begin
                            mem_addr <= src + 32'd4;
                            state    <= ST_RD;
                        end
                    end else if (expired) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= WSTRB_RD;
                        err       <= ERR_TIMEOUT;
                        state     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_mem_dma.sv
// Randomised bench for pico_mem_dma: a behavioural memory responder with
// configurable wait states, checked against an expected-copy model.
module tb_pico_mem_dma;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    pico_mem_dma #(.LEN_W(16), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder state and observation counters
    bit [31:0]   mem [bit [31:0]];
    int          wait_cfg = 0;
    bit          never_ready = 0;
    bit          use_fixed = 0;
    bit          in_beat = 0;
    int          left = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          hs = 0, vcyc = 0, unstable = 0, bad_beat = 0, done_pulses = 0;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
        if (reset) begin
            mem_ready = 1'b0;
            in_beat   = 0;
        end else if (mem_valid !== 1'b1) begin
            in_beat   = 0;
            mem_ready = 1'($urandom_range(0, 1));
        end else begin
            vcyc++;
            if (!in_beat) begin
                in_beat   = 1;
                left      = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
                if ((mem_wstrb !== 4'h0 && mem_wstrb !== 4'hF) || mem_addr[1:0] !== 2'b00)
                    bad_beat++;
            end else if (mem_addr !== cap_addr || mem_wstrb !== cap_wstrb ||
                         (mem_wstrb == 4'hF && mem_wdata !== cap_wdata)) begin
                unstable++;
            end
            if (never_ready || left > 0) begin
                mem_ready = 1'b0;
                if (left > 0) left--;
            end else begin
                mem_ready = 1'b1;
                in_beat   = 0;
                hs++;
                if (mem_wstrb == 4'h0) begin
                    mem_rdata = mem[mem_addr];
                    rd_addr_q.push_back(mem_addr);
                end else begin
                    mem[mem_addr] = mem_wdata;
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end
            end
        end
    end

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int waits, input bit tmo, input bit poke, input string tag);
        bit [31:0]  words[$];
        logic [1:0] exp_err;
        int         exp_hs, exp_lat, c0, lat;
        bit         seen;
        for (int i = 0; i < n; i++) begin
            words.push_back(use_fixed ? 32'h11 * (i + 1) : $urandom());
            mem[s + 32'(4 * i)] = words[i];
        end
        exp_err = (s[1:0] != 2'b00 || d[1:0] != 2'b00) ? 2'd1 : (tmo ? 2'd2 : 2'd0);
        exp_hs  = (exp_err != 2'd0 || n == 0) ? 0 : 2 * n;
        exp_lat = (exp_err != 2'd0 || n == 0) ? 2 : 2 * n + 2;
        hs = 0; vcyc = 0; unstable = 0; bad_beat = 0; done_pulses = 0;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        wait_cfg = waits; never_ready = tmo;

        @(posedge clk); #2;
        src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1; c0 = cyc;
        @(posedge clk); #2;
        start = 1'b0; src_addr = $urandom(); dst_addr = $urandom(); len = 16'($urandom());
        check_eq({tag, " busy_after_start"}, busy, 1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #2;
            start = 1'b1; src_addr = 32'h0000_4000; dst_addr = 32'h0000_5000; len = 16'd9;
            @(posedge clk); #2;
            start = 1'b0;
        end

        seen = 0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            seen = (done === 1'b1);
        end
        check_eq({tag, " done_seen"}, seen, 1);
        lat = cyc - c0;
        if (waits == 0 && !tmo) check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy_at_done"}, busy, 0);
        check_eq({tag, " err"}, err, exp_err);
        @(negedge clk);
        check_eq({tag, " done_one_cycle"}, done, 0);
        check_eq({tag, " err_held"}, err, exp_err);
        check_eq({tag, " done_pulses"}, done_pulses, 1);
        check_eq({tag, " handshakes"}, hs, exp_hs);
        check_eq({tag, " stable"}, unstable, 0);
        check_eq({tag, " beat_format"}, bad_beat, 0);
        if (tmo) check_eq({tag, " valid_cycles"}, vcyc, TMO);
        else if (exp_hs == 0) check_eq({tag, " no_bus"}, vcyc, 0);
        if (exp_hs != 0) begin
            check_eq({tag, " rd_count"}, rd_addr_q.size(), n);
            check_eq({tag, " wr_count"}, wr_addr_q.size(), n);
            for (int i = 0; i < n && i < rd_addr_q.size() && i < wr_addr_q.size(); i++) begin
                check_eq({tag, $sformatf(" rd_addr[%0d]", i)}, rd_addr_q[i], s + 32'(4 * i));
                check_eq({tag, $sformatf(" wr_addr[%0d]", i)}, wr_addr_q[i], d + 32'(4 * i));
                check_eq({tag, $sformatf(" wr_data[%0d]", i)}, wr_data_q[i], words[i]);
            end
        end
        never_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [31:0] s, d;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst mem_valid", mem_valid, 0);
        check_eq("rst mem_addr", mem_addr, 0);
        check_eq("rst mem_wdata", mem_wdata, 0);
        check_eq("rst mem_wstrb", mem_wstrb, 0);
        check_eq("rst mem_instr", mem_instr, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst err", err, 0);
        reset = 1'b0;

        use_fixed = 1;
        run_job(32'h0000_0100, 32'h0000_0200, 3, 0, 0, 0, "t1_basic");
        use_fixed = 0;
        run_job(32'h0000_0300, 32'h0000_0400, 2, 3, 0, 0, "t2_waits");
        run_job(32'h0000_0102, 32'h0000_0200, 2, 0, 0, 0, "t3_src_misalign");
        run_job(32'h0000_0100, 32'h0000_0201, 2, 0, 0, 0, "t3_dst_misalign");
        run_job(32'h0000_0100, 32'h0000_0200, 0, 0, 0, 0, "t3_len0");
        run_job(32'hFFFF_FFFC, 32'h0000_0800, 2, 0, 0, 0, "t4_wrap");
        run_job(32'h0000_0900, 32'h0000_0A00, 2, 0, 1, 0, "t5_timeout");
        run_job(32'h0000_0B00, 32'h0000_0C00, 3, 3, 0, 1, "t6_start_ignored");

        // Reset in the middle of a write wait, with a start presented alongside it
        wait_cfg = 3;
        @(posedge clk); #2;
        src_addr = 32'h0000_0D00; dst_addr = 32'h0000_0E00; len = 16'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = (mem_valid === 1'b1 && mem_wstrb === 4'hF && mem_ready === 1'b0);
        end
        check_eq("t6 wr_wait_reached", seen, 1);
        @(posedge clk); #2;
        reset = 1'b1; start = 1'b1; src_addr = 32'h0000_3000; dst_addr = 32'h0000_3100; len = 16'd4;
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0;
        check_eq("t6 valid_after_reset", mem_valid, 0);
        check_eq("t6 busy_after_reset", busy, 0);
        check_eq("t6 done_after_reset", done, 0);
        done_pulses = 0; vcyc = 0;
        repeat (10) @(negedge clk);
        check_eq("t6 no_done_pulse", done_pulses, 0);
        check_eq("t6 no_bus_after_reset", vcyc, 0);
        run_job(32'h0000_0F00, 32'h0000_1F00, 3, 0, 0, 0, "t6_after_reset");

        for (int j = 0; j < 8; j++) begin
            s = 32'h1000_0000 + 32'($urandom_range(0, 1023)) * 32'd64;
            d = 32'h2000_0000 + 32'($urandom_range(0, 1023)) * 32'd64;
            if ($urandom_range(0, 4) == 0) s = s + 32'($urandom_range(1, 3));
            run_job(s, d, int'($urandom_range(1, 8)), ($urandom_range(0, 1) == 0) ? 0 : -1,
                    0, 0, $sformatf("rand%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
